// File: rtl/cheshire_pkg.sv
// ---------------------------------------------------------------------------
// cheshire_pkg
//
// Shared definitions for the regbus peripheral path:
//   - address_rule_48_t / regbus_periph_addrmap : the periph address map that
//     the regbus watchdog decodes. An entry's position in the map is the demux
//     output index that entry selects.
//   - REGBUS_WD_ERR_DATA : default rdata returned on watchdog-generated errors.
//   - regbus_wd_err_e    : cause code stored in the watchdog error log.
//   - regbus_wd_state_e  : watchdog FSM states.
// ---------------------------------------------------------------------------
package cheshire_pkg;

  // One address window; a hit requires start_addr <= addr < end_addr.
  typedef struct packed {
    logic [47:0] start_addr;
    logic [47:0] end_addr;
  } address_rule_48_t;

  localparam int unsigned REGBUS_PERIPH_NUM_OUTPUTS = 6;

  // Rule 5 is the legacy low-peripheral window. It overlaps UART on purpose,
  // so UART has to stay at a lower index to win the decode.
  localparam address_rule_48_t [REGBUS_PERIPH_NUM_OUTPUTS-1:0] regbus_periph_addrmap = '{
    0: '{start_addr: 48'h0000_0300_0000, end_addr: 48'h0000_0300_1000},  // SoC regs
    1: '{start_addr: 48'h0000_0200_0000, end_addr: 48'h0000_0200_1000},  // UART
    2: '{start_addr: 48'h0000_0300_3000, end_addr: 48'h0000_0300_4000},  // I2C
    3: '{start_addr: 48'h0000_0300_4000, end_addr: 48'h0000_0300_5000},  // SPI host
    4: '{start_addr: 48'h0000_0300_5000, end_addr: 48'h0000_0300_6000},  // GPIO
    5: '{start_addr: 48'h0000_0200_0000, end_addr: 48'h0000_0208_0000}   // legacy window
  };

  localparam logic [31:0] REGBUS_WD_ERR_DATA = 32'hBADC_AB1E;

  typedef enum logic {
    REGBUS_WD_ERR_DECODE  = 1'b0,
    REGBUS_WD_ERR_TIMEOUT = 1'b1
  } regbus_wd_err_e;

  typedef enum logic [1:0] {
    REGBUS_WD_IDLE,
    REGBUS_WD_FWD,
    REGBUS_WD_RESP
  } regbus_wd_state_e;

endpackage

// File: rtl/cheshire_regbus_addr_decode.sv
// ---------------------------------------------------------------------------
// cheshire_regbus_addr_decode
//
// Purely combinational address matcher. A rule hits when
// start_addr <= addr < end_addr; when several rules hit, the lowest index wins.
//
// Ports:
//   addr  in  48        address to decode
//   rules in  NumRules  address rule table
//   hit   out 1         at least one rule matched
//   idx   out IdxW      index of the winning rule (0 on a miss)
// ---------------------------------------------------------------------------
module cheshire_regbus_addr_decode
  import cheshire_pkg::*;
#(
  parameter  int unsigned NumRules = REGBUS_PERIPH_NUM_OUTPUTS,
  localparam int unsigned IdxW     = (NumRules > 1) ? $clog2(NumRules) : 1
) (
  input  logic [47:0]                     addr,
  input  address_rule_48_t [NumRules-1:0] rules,
  output logic                            hit,
  output logic [IdxW-1:0]                 idx
);

  // Scan from the top down so a lower-index match overwrites a higher one.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = int'(NumRules) - 1; i >= 0; i--) begin
      if ((addr >= rules[i].start_addr) && (addr < rules[i].end_addr)) begin
        hit = 1'b1;
        idx = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/cheshire_regbus_watchdog.sv
// ---------------------------------------------------------------------------
// cheshire_regbus_watchdog
//
// Guard stage between the AXI-to-regbus converter and the periph regbus demux.
// A request is latched in IDLE and decoded against the periph address map.
// Mapped requests are forwarded with a demux select; unmapped ones, and
// slaves that keep valid unanswered for TimeoutCycles cycles, get an error
// response (rdata = ErrData) so a bad access can never hang the core.
// All outputs come from registers: there is no combinational path between
// the upstream and downstream sides.
//
// Optional feature: define CHESHIRE_REGBUS_WD_LOG_EN to enable the sticky
// error log (err_valid_o / err_cause_o / err_addr_o, cleared by err_clear_i).
// Without it the log outputs are tied to 0 and err_clear_i is ignored.
//
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   slv_valid_i/slv_write_i        upstream request
//   slv_addr_i/wdata_i/wstrb_i     upstream payload (48/32/4)
//   slv_ready_o/error_o/rdata_o    upstream single-cycle response
//   mst_valid_o/write_o            downstream request
//   mst_addr_o/wdata_o/wstrb_o     downstream payload (latched copy)
//   mst_sel_o                      demux output index
//   mst_ready_i/error_i/rdata_i    downstream response
//   timeout_o, decerr_o            one-cycle event pulses
//   err_clear_i                    clears the error log
//   err_valid_o/cause_o/addr_o     error log contents
// ---------------------------------------------------------------------------
module cheshire_regbus_watchdog
  import cheshire_pkg::*;
#(
  parameter  int unsigned TimeoutCycles = 1024,
  parameter  logic [31:0] ErrData       = REGBUS_WD_ERR_DATA,
  parameter  int unsigned NumRules      = REGBUS_PERIPH_NUM_OUTPUTS,
  localparam int unsigned SelW          = (NumRules > 1) ? $clog2(NumRules) : 1,
  localparam int unsigned CntW          = $clog2(TimeoutCycles + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            slv_valid_i,
  input  logic            slv_write_i,
  input  logic [47:0]     slv_addr_i,
  input  logic [31:0]     slv_wdata_i,
  input  logic [3:0]      slv_wstrb_i,
  output logic            slv_ready_o,
  output logic            slv_error_o,
  output logic [31:0]     slv_rdata_o,
  output logic            mst_valid_o,
  output logic            mst_write_o,
  output logic [47:0]     mst_addr_o,
  output logic [31:0]     mst_wdata_o,
  output logic [3:0]      mst_wstrb_o,
  output logic [SelW-1:0] mst_sel_o,
  input  logic            mst_ready_i,
  input  logic            mst_error_i,
  input  logic [31:0]     mst_rdata_i,
  output logic            timeout_o,
  output logic            decerr_o,
  input  logic            err_clear_i,
  output logic            err_valid_o,
  output logic            err_cause_o,
  output logic [47:0]     err_addr_o
);

  localparam logic [CntW-1:0] CntLimit = CntW'(TimeoutCycles - 1);
  localparam logic [CntW-1:0] CntSat   = CntW'(TimeoutCycles);

  regbus_wd_state_e state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [47:0]      addr_q;
  logic             write_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic [SelW-1:0]  sel_q;
  logic             latch_en;

  logic             resp_err_q, resp_err_d;
  logic [31:0]      resp_rdata_q, resp_rdata_d;
  logic             timeout_q, timeout_d;
  logic             decerr_q, decerr_d;

  logic             dec_hit;
  logic [SelW-1:0]  dec_idx;
  address_rule_48_t [NumRules-1:0] rules;

  for (genvar g = 0; g < NumRules; g++) begin : gen_rules
    assign rules[g] = regbus_periph_addrmap[g];
  end

  cheshire_regbus_addr_decode #(
    .NumRules (NumRules)
  ) i_addr_decode (
    .addr  (slv_addr_i),
    .rules (rules),
    .hit   (dec_hit),
    .idx   (dec_idx)
  );

  // Next-state logic. The counter only matters in FWD; it is cleared on entry
  // and saturates instead of wrapping. A ready in the limit cycle takes
  // priority over the timeout.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    timeout_d    = 1'b0;
    decerr_d     = 1'b0;
    latch_en     = 1'b0;
    unique case (state_q)
      REGBUS_WD_IDLE: begin
        if (slv_valid_i) begin
          latch_en = 1'b1;
          if (dec_hit) begin
            state_d = REGBUS_WD_FWD;
            cnt_d   = '0;
          end else begin
            state_d      = REGBUS_WD_RESP;
            resp_err_d   = 1'b1;
            resp_rdata_d = ErrData;
            decerr_d     = 1'b1;
          end
        end
      end
      REGBUS_WD_FWD: begin
        if (cnt_q != CntSat) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (mst_ready_i) begin
          state_d      = REGBUS_WD_RESP;
          resp_err_d   = mst_error_i;
          resp_rdata_d = mst_rdata_i;
        end else if (cnt_q == CntLimit) begin
          state_d      = REGBUS_WD_RESP;
          resp_err_d   = 1'b1;
          resp_rdata_d = ErrData;
          timeout_d    = 1'b1;
        end
      end
      REGBUS_WD_RESP: begin
        state_d = REGBUS_WD_IDLE;
      end
      default: begin
        state_d = REGBUS_WD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= REGBUS_WD_IDLE;
      cnt_q        <= '0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      timeout_q    <= 1'b0;
      decerr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      timeout_q    <= timeout_d;
      decerr_q     <= decerr_d;
    end
  end

  // Request payload is captured once in IDLE; upstream changes afterwards are
  // ignored for the rest of the transaction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      sel_q   <= '0;
    end else if (latch_en) begin
      addr_q  <= slv_addr_i;
      write_q <= slv_write_i;
      wdata_q <= slv_wdata_i;
      wstrb_q <= slv_wstrb_i;
      sel_q   <= dec_idx;
    end
  end

  assign mst_valid_o = (state_q == REGBUS_WD_FWD);
  assign mst_write_o = write_q;
  assign mst_addr_o  = addr_q;
  assign mst_wdata_o = wdata_q;
  assign mst_wstrb_o = wstrb_q;
  assign mst_sel_o   = sel_q;

  assign slv_ready_o = (state_q == REGBUS_WD_RESP);
  assign slv_error_o = slv_ready_o & resp_err_q;
  assign slv_rdata_o = slv_ready_o ? resp_rdata_q : '0;

  assign timeout_o = timeout_q;
  assign decerr_o  = decerr_q;

`ifdef CHESHIRE_REGBUS_WD_LOG_EN
  regbus_wd_err_e err_cause_q;
  logic           err_valid_q;
  logic [47:0]    err_addr_q;

  // Sticky first-error log. A clear and a new error in the same cycle leave
  // the new error logged, so no event is lost across a clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_valid_q <= 1'b0;
      err_cause_q <= REGBUS_WD_ERR_DECODE;
      err_addr_q  <= '0;
    end else begin
      if (err_clear_i) begin
        err_valid_q <= 1'b0;
        err_cause_q <= REGBUS_WD_ERR_DECODE;
        err_addr_q  <= '0;
      end
      if ((decerr_d || timeout_d) && (!err_valid_q || err_clear_i)) begin
        err_valid_q <= 1'b1;
        err_cause_q <= timeout_d ? REGBUS_WD_ERR_TIMEOUT : REGBUS_WD_ERR_DECODE;
        err_addr_q  <= decerr_d ? slv_addr_i : addr_q;
      end
    end
  end

  assign err_valid_o = err_valid_q;
  assign err_cause_o = err_cause_q;
  assign err_addr_o  = err_addr_q;
`else
  logic unused_err_clear;
  assign unused_err_clear = err_clear_i;

  assign err_valid_o = 1'b0;
  assign err_cause_o = 1'b0;
  assign err_addr_o  = '0;
`endif

endmodule
